// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: mode encodings,
// FSM state type and the bit-counter width helper.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Never returns less than 1, so WIDTH=2 still gets a one-bit counter.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_addsub_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell of
// the serial adder/subtractor.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: resolves one result bit per clock through a
// single full-adder cell, with carry/no-borrow and signed-overflow flags.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry_reg;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last_bit;
    logic             cell_s;
    logic             cell_cout;

    full_add_cell u_cell (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry_reg),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (count == LAST);
    assign res_next = {cell_s, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: the inverted operand and the preset carry
    // are set up once at accept, so the cell itself never knows the mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            res_sr    <= '0;
            carry_reg <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            op_a      <= a;
            op_b      <= (mode == MODE_SUB) ? ~b : b;
            carry_reg <= mode;
            count     <= '0;
        end else if (state == RUN) begin
            op_a      <= op_a >> 1;
            op_b      <= op_b >> 1;
            res_sr    <= res_next;
            carry_reg <= cell_cout;
            count     <= count + CW'(1);
            if (last_bit) begin
                sum      <= res_next;
                carry    <= cell_cout;
                overflow <= carry_reg ^ cell_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub: WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep against an arithmetic reference.
module tb_serial_addsub;

    logic       clk;
    logic       rst;

    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;
    logic       overflow;

    logic       start4;
    logic       mode4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ready4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       carry4;
    logic       overflow4;

    int tests;
    int failures;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .mode     (mode4),
        .a        (a4),
        .b        (b4),
        .ready    (ready4),
        .busy     (busy4),
        .done     (done4),
        .sum      (sum4),
        .carry    (carry4),
        .overflow (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge, then waits (bounded) for done.
    task automatic apply_stimulus(input logic m, input logic [7:0] x,
                                  input logic [7:0] y, output int cycles);
        a = x;
        b = y;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic apply_stimulus4(input logic m, input logic [3:0] x,
                                   input logic [3:0] y, output int cycles);
        a4 = x;
        b4 = y;
        mode4 = m;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cycles = 0;
        while (done4 !== 1'b1 && cycles < 12) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int         cycles;
        logic       seen_done;
        logic       changed;
        logic [3:0] xv;
        logic [3:0] yv;
        logic [4:0] full;
        logic [3:0] exp_sum;
        logic       exp_c;
        logic       exp_ov;

        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        a        = '0;
        b        = '0;
        start4   = 1'b0;
        mode4    = 1'b0;
        a4       = '0;
        b4       = '0;

        tick();
        tick();
        check_output("reset_ready", ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_sum", sum, 0);
        check_output("reset_carry", carry, 0);
        check_output("reset_overflow", overflow, 0);
        check_output("reset_ready4", ready4, 1);
        rst = 1'b0;
        tick();

        // Basic add with exact latency and a one-cycle done pulse.
        a = 8'h5A;
        b = 8'h33;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("add_busy_after_accept", busy, 1);
        check_output("add_ready_after_accept", ready, 0);
        seen_done = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check_output("add_no_early_done", seen_done, 0);
        check_output("add_busy_last_bit", busy, 1);
        tick();
        check_output("add_done_at_edge8", done, 1);
        check_output("add_sum", sum, 8'h8D);
        check_output("add_carry", carry, 0);
        check_output("add_overflow", overflow, 1);
        check_output("add_ready_in_done", ready, 1);
        tick();
        check_output("add_done_one_cycle", done, 0);
        check_output("add_back_to_idle_ready", ready, 1);

        // Boundary cases.
        apply_stimulus(1'b0, 8'h80, 8'h80, cycles);
        check_output("add8080_latency", cycles, 8);
        check_output("add8080_sum", sum, 8'h00);
        check_output("add8080_carry", carry, 1);
        check_output("add8080_overflow", overflow, 1);
        tick();

        apply_stimulus(1'b1, 8'h10, 8'h20, cycles);
        check_output("sub1020_done", done, 1);
        check_output("sub1020_sum", sum, 8'hF0);
        check_output("sub1020_carry", carry, 0);
        check_output("sub1020_overflow", overflow, 0);
        tick();

        apply_stimulus(1'b1, 8'h80, 8'h01, cycles);
        check_output("sub8001_done", done, 1);
        check_output("sub8001_sum", sum, 8'h7F);
        check_output("sub8001_carry", carry, 1);
        check_output("sub8001_overflow", overflow, 1);
        tick();

        // Results must hold while inputs wander with start low.
        seen_done = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            mode = 1'($urandom);
            tick();
            if (done) seen_done = 1'b1;
            if (sum !== 8'h7F || carry !== 1'b1 || overflow !== 1'b1) changed = 1'b1;
        end
        check_output("hold_no_done", seen_done, 0);
        check_output("hold_unchanged", changed, 0);
        check_output("hold_sum", sum, 8'h7F);

        // Start during RUN is ignored.
        a = 8'hFF;
        b = 8'h01;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'h00;
        b = 8'h00;
        mode = 1'b1;
        start = 1'b1;
        tick();
        tick();
        tick();
        check_output("busy_start_still_busy", busy, 1);
        start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check_output("busy_start_latency", cycles, 3);
        check_output("busy_start_sum", sum, 8'h00);
        check_output("busy_start_carry", carry, 1);
        check_output("busy_start_overflow", overflow, 0);
        tick();

        // Back-to-back with start held through DONE; operand change mid-RUN is ignored.
        a = 8'h10;
        b = 8'h20;
        mode = 1'b0;
        start = 1'b1;
        tick();
        a = 8'h7F;
        b = 8'h01;
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check_output("b2b_first_done", done, 1);
        check_output("b2b_first_sum", sum, 8'h30);
        check_output("b2b_first_carry", carry, 0);
        tick();
        start = 1'b0;
        check_output("b2b_no_idle_gap", busy, 1);
        check_output("b2b_done_dropped", done, 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check_output("b2b_second_latency", cycles, 8);
        check_output("b2b_second_sum", sum, 8'h80);
        check_output("b2b_second_overflow", overflow, 1);
        tick();

        // Reset mid-operation after the third RUN edge.
        a = 8'h55;
        b = 8'h22;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst_busy", busy, 0);
        check_output("midrst_ready", ready, 1);
        check_output("midrst_sum", sum, 0);
        check_output("midrst_carry", carry, 0);
        check_output("midrst_overflow", overflow, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check_output("midrst_no_done", seen_done, 0);
        apply_stimulus(1'b0, 8'h01, 8'h01, cycles);
        check_output("after_rst_done", done, 1);
        check_output("after_rst_sum", sum, 8'h02);
        check_output("after_rst_carry", carry, 0);
        tick();

        // Exhaustive WIDTH=4 sweep.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    xv = 4'(x);
                    yv = 4'(y);
                    if (m == 0) begin
                        full    = {1'b0, xv} + {1'b0, yv};
                        exp_sum = full[3:0];
                        exp_c   = full[4];
                        exp_ov  = (xv[3] == yv[3]) && (exp_sum[3] != xv[3]);
                    end else begin
                        exp_sum = xv - yv;
                        exp_c   = (x >= y);
                        exp_ov  = (xv[3] != yv[3]) && (exp_sum[3] != xv[3]);
                    end
                    apply_stimulus4(1'(m), xv, yv, cycles);
                    check_output($sformatf("w4_m%0d_%0h_%0h_done", m, x, y), done4, 1);
                    check_output($sformatf("w4_m%0d_%0h_%0h_sum", m, x, y), sum4, exp_sum);
                    check_output($sformatf("w4_m%0d_%0h_%0h_carry", m, x, y), carry4, exp_c);
                    check_output($sformatf("w4_m%0d_%0h_%0h_ovf", m, x, y), overflow4, exp_ov);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
